// File: rtl/imem_loader_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : imem_loader_pkg
//  Description : Shared constants and loader state encoding for the
//                instruction-memory boot loader.
//  Revision    : 1.0  initial release
// ============================================================================
package imem_loader_pkg;

  localparam int IMEM_ADDR_W = 6;
  localparam int HDR_BYTES   = 4;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_HDR  = 3'd1,
    ST_DATA = 3'd2,
    ST_CSUM = 3'd3,
    ST_DONE = 3'd4,
    ST_ERR  = 3'd5
  } loader_state_t;

  // True in the states that consume bytes from the stream.
  function automatic logic is_loading(loader_state_t s);
    return (s == ST_HDR) || (s == ST_DATA) || (s == ST_CSUM);
  endfunction

endpackage
`default_nettype wire

// File: rtl/imem_loader_if.sv
`default_nettype none
// ============================================================================
//  Module      : imem_loader_if
//  Description : Byte-stream input and imem write port of the boot loader.
//                master = stream source / memory side, slave = loader.
//  Revision    : 1.0  initial release
// ============================================================================
interface imem_loader_if #(
  parameter int ADDR_W = 6
);
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wd;

  modport master (
    output rx_data, rx_valid,
    input  rx_ready, mem_we, mem_addr, mem_wd
  );

  modport slave (
    input  rx_data, rx_valid,
    output rx_ready, mem_we, mem_addr, mem_wd
  );
endinterface
`default_nettype wire

// File: rtl/imem_loader_word_assembler.sv
`default_nettype none
// ============================================================================
//  Module      : imem_loader_word_assembler
//  Description : Big-endian byte-to-word assembler. Keeps the three earlier
//                bytes of a word; the full word is presented combinationally
//                together with the fourth byte, flagged by o_word_full.
//  Revision    : 1.0  initial release
// ============================================================================
module imem_loader_word_assembler
  import imem_loader_pkg::*;
(
  input  wire logic        clk,
  input  wire logic        reset,
  input  wire logic        i_clr,
  input  wire logic        i_en,
  input  wire logic [7:0]  i_byte,
  output logic      [31:0] o_word,
  output logic             o_word_full
);

  localparam int          CNT_W    = $clog2(HDR_BYTES);
  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(HDR_BYTES - 1);

  logic [23:0]      r_shift;
  logic [CNT_W-1:0] r_cnt;

  // Shift accepted bytes in MSB-first; the byte counter wraps every word.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_shift <= '0;
      r_cnt   <= '0;
    end else if (i_clr) begin
      r_cnt   <= '0;
    end else if (i_en) begin
      r_shift <= {r_shift[15:0], i_byte};
      r_cnt   <= r_cnt + CNT_W'(1);
    end
  end

  assign o_word      = {r_shift, i_byte};
  assign o_word_full = i_en && (r_cnt == C_LAST);

endmodule
`default_nettype wire

// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
//  Module      : imem_loader
//  Description : Boot-image loader. Parses a header word N, writes N
//                big-endian words into imem and verifies an XOR checksum
//                byte. The core is held until the image is verified.
//  Revision    : 1.0  initial release
// ============================================================================
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_W = IMEM_ADDR_W
) (
  input  wire logic          clk,
  input  wire logic          reset,
  input  wire logic          start,
  imem_loader_if.slave       bus,
  output logic               cpu_hold,
  output logic               done,
  output logic               error,
  output logic [ADDR_W:0]    words_loaded
);

  localparam int          CW      = ADDR_W + 1;
  localparam logic [31:0] C_DEPTH = 32'(1) << ADDR_W;

  loader_state_t   r_state;
  loader_state_t   w_next;

  logic            w_accept;
  logic            w_start_ok;
  logic            w_last_word;
  logic [31:0]     w_word;
  logic            w_word_full;

  logic [7:0]        r_csum;
  logic [CW-1:0]     r_n;
  logic [CW-1:0]     r_word_idx;
  logic [CW-1:0]     r_words_loaded;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [31:0]       r_mem_wd;

  assign w_accept    = bus.rx_valid && bus.rx_ready;
  assign w_start_ok  = start && !is_loading(r_state);
  assign w_last_word = ((r_word_idx + CW'(1)) == r_n);

  imem_loader_word_assembler u_asm (
    .clk         (clk),
    .reset       (reset),
    .i_clr       (w_start_ok),
    .i_en        (w_accept),
    .i_byte      (bus.rx_data),
    .o_word      (w_word),
    .o_word_full (w_word_full)
  );

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state decode and state-derived status outputs.
  always_comb begin
    w_next       = r_state;
    bus.rx_ready = is_loading(r_state);
    cpu_hold     = (r_state != ST_DONE);
    done         = (r_state == ST_DONE);
    error        = (r_state == ST_ERR);
    case (r_state)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (start) w_next = ST_HDR;
      end
      ST_HDR: begin
        if (w_word_full) begin
          if (w_word > C_DEPTH)    w_next = ST_ERR;
          else if (w_word == '0)   w_next = ST_CSUM;
          else                     w_next = ST_DATA;
        end
      end
      ST_DATA: begin
        if (w_word_full && w_last_word) w_next = ST_CSUM;
      end
      ST_CSUM: begin
        if (w_accept) w_next = (bus.rx_data == r_csum) ? ST_DONE : ST_ERR;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // Checksum, counters and the registered imem write port. The write of a
  // word is issued the cycle after its fourth byte, so the strobe of the
  // final word coincides with the first cycle of the checksum phase.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_csum         <= '0;
      r_n            <= '0;
      r_word_idx     <= '0;
      r_words_loaded <= '0;
      r_mem_we       <= 1'b0;
      r_mem_addr     <= '0;
      r_mem_wd       <= '0;
    end else begin
      r_mem_we <= 1'b0;
      if (w_start_ok) begin
        r_csum         <= '0;
        r_n            <= '0;
        r_word_idx     <= '0;
        r_words_loaded <= '0;
      end else if (w_accept && (r_state != ST_CSUM)) begin
        r_csum <= r_csum ^ bus.rx_data;
      end
      if ((r_state == ST_HDR) && w_word_full) begin
        // Only used when the header passed the depth check, so it fits.
        r_n <= w_word[CW-1:0];
      end
      if ((r_state == ST_DATA) && w_word_full) begin
        r_mem_we       <= 1'b1;
        r_mem_addr     <= r_word_idx[ADDR_W-1:0];
        r_mem_wd       <= w_word;
        r_word_idx     <= r_word_idx + CW'(1);
        r_words_loaded <= r_words_loaded + CW'(1);
      end
    end
  end

  assign bus.mem_we   = r_mem_we;
  assign bus.mem_addr = r_mem_addr;
  assign bus.mem_wd   = r_mem_wd;
  assign words_loaded = r_words_loaded;

endmodule
`default_nettype wire
